// File: rtl/wb_serializer_sched_pkg.sv
// -----------------------------------------------------------------------------
// wb_serializer_sched_pkg
// Shared definitions for the serializer scheduler: packet geometry, the K28.5
// idle packet and the scheduler state encoding.
// -----------------------------------------------------------------------------
package wb_serializer_sched_pkg;

  // A packet is three 9-bit symbols, each {k, byte}.
  localparam int PKT_W = 27;
  localparam int SER_W = 32;

  localparam logic [8:0]       K28_5_SYM = 9'h1BC;
  localparam logic [PKT_W-1:0] IDLE_PKT  = {3{K28_5_SYM}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } sched_state_t;

  // Serializer word layout: packet right-aligned, upper bits zero.
  function automatic logic [SER_W-1:0] pack_ser(input logic [PKT_W-1:0] pkt);
    return {{(SER_W - PKT_W){1'b0}}, pkt};
  endfunction

endpackage

// File: rtl/wb_serializer_sched_if.sv
// -----------------------------------------------------------------------------
// wb_serializer_sched_if
// Bundles the requester side and the serializer side of the scheduler.
//   master : the scheduler (drives ready, start, data, grant, status)
//   slave  : requesters + serializer (drive enable, valid, data, done)
// Signals:
//   enable_i     scheduler enable
//   req_valid_i  per-channel packet valid
//   req_data_i   packed packets, channel i at [27*i+26:27*i]
//   req_ready_o  per-channel accept, one-hot or zero
//   ser_start_o  one-cycle start pulse to the serializer
//   ser_data_o   {5'b0, packet} to the serializer
//   ser_done_i   serializer end-of-packet pulse
//   grant_o      one-hot owner of the packet in flight
//   busy_o       high while a packet is in START or BUSY
//   err_o        one-cycle timeout pulse
//   err_ch_o     channel of the last timeout
// -----------------------------------------------------------------------------
interface wb_serializer_sched_if
  import wb_serializer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int IDX_W = $clog2(NUM_REQ);

  logic                     enable_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*PKT_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     ser_start_o;
  logic [SER_W-1:0]         ser_data_o;
  logic                     ser_done_i;
  logic [NUM_REQ-1:0]       grant_o;
  logic                     busy_o;
  logic                     err_o;
  logic [IDX_W-1:0]         err_ch_o;

  modport master (
    input  enable_i, req_valid_i, req_data_i, ser_done_i,
    output req_ready_o, ser_start_o, ser_data_o, grant_o, busy_o, err_o, err_ch_o
  );

  modport slave (
    output enable_i, req_valid_i, req_data_i, ser_done_i,
    input  req_ready_o, ser_start_o, ser_data_o, grant_o, busy_o, err_o, err_ch_o
  );

endinterface

// File: rtl/wb_serializer_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request found searching
// upward from ptr, wrapping at N.
// Ports:
//   req      request vector
//   ptr      highest-priority index this cycle
//   gnt      one-hot winner (zero when nothing requested)
//   gnt_idx  binary index of the winner
//   any      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int c;
    c       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        any     = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = IW'(c);
      end
    end
  end

endmodule

// File: rtl/wb_serializer_sched.sv
// -----------------------------------------------------------------------------
// wb_serializer_sched
// Round-robin scheduler sharing one serializer among NUM_REQ requesters.
// One packet is in flight at a time: accept in IDLE, pulse start in START,
// wait for ser_done_i in BUSY. A BUSY phase lasting TIMEOUT cycles without
// done is abandoned with an err_o pulse naming the owning channel.
//
// Optional feature (macro SCHED_IDLE_KCODE_EN): after IDLE_GAP idle cycles
// with the scheduler enabled and no requests, a K28.5 x3 packet is sent with
// no owner.
//
// Ports:
//   CLK_I  clock
//   RST_I  synchronous reset, active-high
//   bus    wb_serializer_sched_if.master (requester + serializer signals)
// -----------------------------------------------------------------------------
module wb_serializer_sched
  import wb_serializer_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TIMEOUT  = 64,
  parameter int IDLE_GAP = 16
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  wb_serializer_sched_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || IDLE_GAP < 1) begin : g_param_check
    $error("wb_serializer_sched: parameter out of range");
  end

  sched_state_t       state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [TMR_W-1:0]   timer;
  logic [SER_W-1:0]   ser_data_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               err_q;
  logic [IDX_W-1:0]   err_ch_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic take_req;
  logic take_idle;
  logic cur_is_idle;
  logic timeout_hit;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (bus.req_valid_i),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign take_req = (state == IDLE) && bus.enable_i && arb_any;

`ifdef SCHED_IDLE_KCODE_EN
  localparam int IC_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  logic [IC_W-1:0] idle_cnt;
  logic            idle_run;

  // The counter only advances on truly empty enabled IDLE cycles, so any
  // request seen on the hit cycle takes priority through take_req.
  assign idle_run  = (state == IDLE) && bus.enable_i && !arb_any;
  assign take_idle = idle_run && (idle_cnt == IC_W'(IDLE_GAP - 1));

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      idle_cnt    <= '0;
      cur_is_idle <= 1'b0;
    end else begin
      if (idle_run && !take_idle) idle_cnt <= idle_cnt + 1'b1;
      else                        idle_cnt <= '0;
      if (take_req)       cur_is_idle <= 1'b0;
      else if (take_idle) cur_is_idle <= 1'b1;
    end
  end
`else
  assign take_idle   = 1'b0;
  assign cur_is_idle = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:  if (take_req || take_idle) state_nxt = START;
      START: state_nxt = BUSY;
      BUSY: begin
        // done has priority over the timeout in the same cycle
        if (bus.ser_done_i) begin
          state_nxt = IDLE;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_idx    <= '0;
      timer      <= '0;
      ser_data_q <= '0;
      grant_q    <= '0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
    end else begin
      state <= state_nxt;
      err_q <= timeout_hit;
      if (timeout_hit && !cur_is_idle) err_ch_q <= cur_idx;

      if (state == START)     timer <= '0;
      else if (state == BUSY) timer <= timer + 1'b1;

      if (take_req) begin
        ser_data_q <= pack_ser(bus.req_data_i[int'(arb_idx)*PKT_W +: PKT_W]);
        grant_q    <= arb_gnt;
        cur_idx    <= arb_idx;
        rr_ptr     <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end else if (take_idle) begin
        ser_data_q <= pack_ser(IDLE_PKT);
        grant_q    <= '0;
      end else if (state == BUSY && state_nxt == IDLE) begin
        grant_q    <= '0;
      end
    end
  end

  assign bus.req_ready_o = take_req ? arb_gnt : '0;
  assign bus.ser_start_o = (state == START);
  assign bus.ser_data_o  = ser_data_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = (state != IDLE);
  assign bus.err_o       = err_q;
  assign bus.err_ch_o    = err_ch_q;

endmodule

// File: doc/wb_serializer_sched.md
Name: wb_serializer_sched

Overview:
- Round-robin scheduler that shares one serializer channel among NUM_REQ packet requesters.
- Each packet is 27 bits: three 9-bit symbols, each {k, 8-bit}; k=1 means K-code, k=0 means data.
- Sits between the requesters and the serializer. Drives the serializer's start/data inputs and waits for its end-of-packet indication before issuing the next grant.
- Adds a completion timeout and error reporting; optionally inserts K28.5 idle packets.

Parameters:
- NUM_REQ, 4, number of requester channels (2..8).
- TIMEOUT, 64, maximum BUSY cycles allowed without ser_done_i.
- IDLE_GAP, 16, consecutive empty IDLE cycles before an idle packet is sent (optional feature only).

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous reset, active-high.
- enable_i  in  1  scheduler enable; when low, no new grants.
- req_valid_i  in  NUM_REQ  per-channel packet valid.
- req_data_i  in  NUM_REQ*27  packed packets; channel i is at [27*i+26:27*i].
- req_ready_o  out  NUM_REQ  per-channel accept; one-hot or zero.
- ser_start_o  out  1  one-cycle start pulse to the serializer.
- ser_data_o  out  32  packet to the serializer, {5'b0, pkt[26:0]}.
- ser_done_i  in  1  serializer end-of-packet pulse (its packet counter reaching 3).
- grant_o  out  NUM_REQ  one-hot owner of the packet in flight; 0 otherwise.
- busy_o  out  1  high in START and BUSY.
- err_o  out  1  one-cycle pulse on timeout.
- err_ch_o  out  $clog2(NUM_REQ)  channel that timed out; held until the next error.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = 0 (channel 0 has highest priority first); timer 0.
- Reset mid-operation: packet is abandoned, no err_o, and no ready is reissued for it.
- States: IDLE, START, BUSY.
- IDLE with enable_i=1 and any valid:
  - Winner is the first valid channel searching upward, with wrap, from the pointer.
  - req_ready_o[winner] = 1, combinational, this cycle only; transfer occurs at the clock edge.
  - At the edge: ser_data_o and grant_o are latched, pointer = winner+1 mod NUM_REQ, next state START.
- IDLE with enable_i=0 or no valid: req_ready_o = 0, stay in IDLE.
- START: ser_start_o = 1 for exactly one cycle; timer cleared; next state BUSY.
- BUSY:
  - Timer increments each cycle.
  - ser_done_i=1 gives next state IDLE; grant_o clears at that edge.
  - Timer reaching TIMEOUT-1 without done: err_o pulses, err_ch_o = granted index, next state IDLE.
  - If done and timeout occur in the same cycle, done wins and no error is raised.
- ser_done_i outside BUSY is ignored.
- ser_data_o holds its value from the load until the next load; it never changes during START or BUSY.
- Minimum packet-to-packet spacing: accept (cycle N), start (N+1), BUSY from N+2, done (cycle D), next accept at D+1.
- enable_i falling during START or BUSY: the in-flight packet completes normally.
- req_valid_i falling without a handshake: channel is simply not considered.
- Requesters must hold data stable while valid is high.

Optional Feature:
- Macro: SCHED_IDLE_KCODE_EN.
- With the macro defined:
  - An idle counter runs in IDLE while enable_i=1 and no valid is present; it is cleared otherwise.
  - When the counter reaches IDLE_GAP-1, the block loads K28.5 x3 (27'h6F379BC), then runs START and BUSY as normal.
  - For this packet grant_o = 0, no req_ready_o is asserted, and the round-robin pointer is unchanged.
  - A timeout on this packet raises err_o with err_ch_o unchanged.
  - A real request present in the same cycle as the counter hit wins over the idle packet.
- Without the macro: no idle counter; the serializer stays quiet when no requests are present.

Decomposition:
- Package WBSerializer holds:
  - PKT_W = 27.
  - K28_5_SYM = 9'h1BC.
  - IDLE_PKT = {3{K28_5_SYM}}.
  - typedef enum sched_state_t {IDLE, START, BUSY}.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Purely combinational.
- FSM, timer, data latch and idle logic stay in the top module.

Test Plan:
- Single channel: valid[2]=1, data=27'h0123456 → ready[2] for 1 cycle; ser_start_o 1 cycle later; ser_data_o=32'h00123456; grant_o=4'b0100 until done.
- Fairness: all four channels valid continuously with done after 5 BUSY cycles → grant order 0,1,2,3,0,1; no channel served twice in a row.
- Timeout: grant channel 1, hold ser_done_i=0 → err_o pulses after 64 BUSY cycles; err_ch_o=1; back to IDLE; next grant goes to channel 2.
- Collision: done and timeout in the same cycle → no err_o; enable_i dropped in BUSY → packet finishes and no further ready is issued.
- Reset mid-BUSY: RST_I for 1 cycle → all outputs 0; first grant afterwards is channel 0 when channels 0 and 3 are both valid.
- Idle feature (SCHED_IDLE_KCODE_EN): no valid for 16 cycles → ser_start_o with ser_data_o=32'h06F379BC and grant_o=0; a valid arriving on the 16th cycle is granted instead.
